// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache miss-fill sequencer.
//   fill_state_e : sequencer states IDLE -> FILL -> DONE -> IDLE
//   grant_e      : which cache owns the current fill (GNT_I / GNT_D)
//   MEM_LATENCY  : nominal memory read latency; the sequencer itself follows
//                  mem_data_valid, so this is a system characteristic only.
package cache_pkg;

    localparam int unsigned WORDS_PER_BLK = 8;
    localparam int unsigned WORD_W        = $clog2(WORDS_PER_BLK);
    localparam int unsigned BLK_OFFSET_W  = 4;
    localparam int unsigned MEM_LATENCY   = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_e;

endpackage

// File: rtl/fill_arbiter.sv
// fill_arbiter: two-requester arbiter for the fill sequencer; registers the
// granted cache when the sequencer accepts a miss.
// Optional feature macro: CACHE_FILL_RR_EN
//   defined   -> round-robin tie-break (tie goes to the cache not served last)
//   undefined -> fixed priority, D-cache wins ties
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   i_req_i/i_req_d I-cache / D-cache miss requests
//   i_grant_en      latch the current winner into the grant register
//   i_fill_done     (round-robin build only) a fill is completing this cycle
//   o_win           combinational winner (GNT_I=0 / GNT_D=1)
//   o_grant         registered grant for the fill in progress
module fill_arbiter
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_grant_en,
`ifdef CACHE_FILL_RR_EN
    input  logic i_fill_done,
`endif
    output logic o_win,
    output logic o_grant
);

    grant_e r_grant;
    grant_e w_win;

`ifdef CACHE_FILL_RR_EN
    // Remembers who was served last; starts at I so the first tie goes to D.
    grant_e r_last;

    always_comb begin
        w_win = GNT_D;
        if (i_req_i && i_req_d) begin
            w_win = (r_last == GNT_I) ? GNT_D : GNT_I;
        end else if (i_req_i) begin
            w_win = GNT_I;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= GNT_I;
        end else if (i_fill_done) begin
            r_last <= r_grant;
        end
    end
`else
    always_comb begin
        w_win = GNT_D;
        if (i_req_i && !i_req_d) begin
            w_win = GNT_I;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant <= GNT_I;
        end else if (i_grant_en) begin
            r_grant <= w_win;
        end
    end

    assign o_win   = w_win;
    assign o_grant = r_grant;

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-handling sequencer shared by the I-cache and D-cache.
// Arbitrates simultaneous misses, issues 8 pipelined word reads to main memory,
// pulses the granted cache's Write_Data_Array strobe per returned word and the
// Write_Tag_Array strobe with the last word, and stalls the pipeline while busy.
// Optional feature macro: CACHE_FILL_RR_EN (round-robin tie-break in fill_arbiter).
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   icache_miss/icache_addr    I-cache miss and missing byte address
//   dcache_miss/dcache_addr    D-cache miss and missing byte address
//   mem_data_valid             memory returns one word this cycle
//   mem_en/mem_addr            memory read issue and address
//   icache_wr_data/_wr_tag     I-cache data/tag write strobes
//   dcache_wr_data/_wr_tag     D-cache data/tag write strobes
//   word_num                   word index of the word being written
//   fill_busy                  fill in progress (pipeline stall)
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              mem_data_valid,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              icache_wr_data,
    output logic              icache_wr_tag,
    output logic              dcache_wr_data,
    output logic              dcache_wr_tag,
    output logic [WORD_W-1:0] word_num,
    output logic              fill_busy
);

    // Issue counter carries one extra bit so it can sit at 8 and stop issuing.
    localparam int unsigned       ISSUE_W  = WORD_W + 1;
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BLK_OFFSET_W) - 1);

    fill_state_e        r_state;
    fill_state_e        w_next;
    logic [ISSUE_W-1:0] r_issue_cnt;
    logic [WORD_W-1:0]  r_ret_cnt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  w_win_addr;
    logic               w_win;
    logic               w_grant;
    logic               w_grant_en;
    logic               w_issue;

    fill_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (icache_miss),
        .i_req_d    (dcache_miss),
        .i_grant_en (w_grant_en),
`ifdef CACHE_FILL_RR_EN
        .i_fill_done(r_state == DONE),
`endif
        .o_win      (w_win),
        .o_grant    (w_grant)
    );

    assign w_win_addr = (w_win == GNT_D) ? dcache_addr : icache_addr;
    assign word_num   = r_ret_cnt;

    always_comb begin
        w_next         = r_state;
        w_grant_en     = 1'b0;
        w_issue        = 1'b0;
        mem_en         = 1'b0;
        mem_addr       = '0;
        icache_wr_data = 1'b0;
        icache_wr_tag  = 1'b0;
        dcache_wr_data = 1'b0;
        dcache_wr_tag  = 1'b0;
        fill_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                // Stall is combinational from the miss, but forced low in reset.
                fill_busy = rst && (icache_miss || dcache_miss);
                if (icache_miss || dcache_miss) begin
                    w_grant_en = 1'b1;
                    w_next     = FILL;
                end
            end
            FILL: begin
                fill_busy = 1'b1;
                w_issue   = !r_issue_cnt[ISSUE_W-1];
                mem_en    = w_issue;
                if (w_issue) begin
                    mem_addr = r_base | ADDR_W'({r_issue_cnt[WORD_W-1:0], 1'b0});
                end
                if (mem_data_valid) begin
                    if (w_grant == GNT_D) begin
                        dcache_wr_data = 1'b1;
                    end else begin
                        icache_wr_data = 1'b1;
                    end
                    if (r_ret_cnt == WORD_W'(WORDS_PER_BLK - 1)) begin
                        if (w_grant == GNT_D) begin
                            dcache_wr_tag = 1'b1;
                        end else begin
                            icache_wr_tag = 1'b1;
                        end
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                fill_busy = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Return counter wraps to 0 on the 8th word, so word_num reads 0 outside a fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_base      <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_en) begin
                r_base      <= w_win_addr & ~BLK_MASK;
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end else if (r_state == FILL) begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + ISSUE_W'(1);
                end
                if (mem_data_valid) begin
                    r_ret_cnt <= r_ret_cnt + WORD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed bench for cache_fill_ctrl with a pipelined
// memory model of adjustable latency. Honours CACHE_FILL_RR_EN for tie order.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_addr;
    logic        dcache_miss;
    logic [15:0] dcache_addr;
    logic        mem_data_valid;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        icache_wr_data;
    logic        icache_wr_tag;
    logic        dcache_wr_data;
    logic        dcache_wr_tag;
    logic [2:0]  word_num;
    logic        fill_busy;

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 4;
    logic [15:0] r_mpipe  = '0;

    always #5 clk = ~clk;

    // Memory: each issued read returns exactly lat cycles later; not reset,
    // so reads in flight at a reset still come back.
    always @(posedge clk) r_mpipe <= {r_mpipe[14:0], mem_en};
    assign mem_data_valid = r_mpipe[4'(lat - 1)];

    cache_fill_ctrl #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_miss   (icache_miss),
        .icache_addr   (icache_addr),
        .dcache_miss   (dcache_miss),
        .dcache_addr   (dcache_addr),
        .mem_data_valid(mem_data_valid),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .icache_wr_data(icache_wr_data),
        .icache_wr_tag (icache_wr_tag),
        .dcache_wr_data(dcache_wr_data),
        .dcache_wr_tag (dcache_wr_tag),
        .word_num      (word_num),
        .fill_busy     (fill_busy)
    );

    // Expected outputs k cycles after the grant cycle (k=0) for a fill of
    // cache d (1=D) at block base with memory latency l.
    // Layout: {busy, mem_en, mem_addr, iwd, iwt, dwd, dwt, word_num}
    function automatic logic [24:0] exp_vec(int k, bit d, logic [15:0] base, int l);
        logic        fb, men, wd, wt;
        logic [15:0] addr;
        logic [2:0]  wn;
        fb   = (k >= 0) && (k <= 9 + l);
        men  = (k >= 1) && (k <= 8);
        addr = men ? base + 16'(2 * (k - 1)) : 16'h0000;
        wd   = (k >= 1 + l) && (k <= 8 + l);
        wt   = (k == 8 + l);
        wn   = wd ? 3'(k - 1 - l) : 3'd0;
        return {fb, men, addr, !d && wd, !d && wt, d && wd, d && wt, wn};
    endfunction

    // word_num only matters while a data strobe is up.
    function automatic logic [24:0] obs_vec();
        logic [2:0] wn;
        wn = (icache_wr_data || dcache_wr_data) ? word_num : 3'd0;
        return {fill_busy, mem_en, mem_addr, icache_wr_data, icache_wr_tag,
                dcache_wr_data, dcache_wr_tag, wn};
    endfunction

    task automatic test_reset();
        rst = 1'b1; icache_miss = 1'b0; dcache_miss = 1'b0;
        icache_addr = '0; dcache_addr = '0;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", obs_vec(), 25'd0);
        end
        icache_miss = 1'b1; dcache_miss = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++; $display("FAIL reset_miss got=%h exp=%h", obs_vec(), 25'd0);
        end
        icache_miss = 1'b0; dcache_miss = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", obs_vec(), 25'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_i_miss();
        logic [24:0] e;
        lat = 4; icache_addr = 16'h1236; icache_miss = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            if (k == 13) icache_miss = 1'b0;
            @(negedge clk);
            e = exp_vec(k, 1'b0, 16'h1230, 4);
            checks++;
            if (obs_vec() !== e) begin
                failures++; $display("FAIL i_miss k=%0d got=%h exp=%h", k, obs_vec(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_tie();
        bit          f_d[3];
        logic [15:0] f_base[3];
        logic [24:0] e;
`ifdef CACHE_FILL_RR_EN
        f_d = '{1'b1, 1'b0, 1'b1}; f_base = '{16'hA0F0, 16'h5670, 16'hB100};
`else
        f_d = '{1'b1, 1'b1, 1'b0}; f_base = '{16'hA0F0, 16'hB100, 16'h5670};
`endif
        lat = 4;
        icache_addr = 16'h5678; dcache_addr = 16'hA0F2;
        icache_miss = 1'b1; dcache_miss = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k <= 13; k++) begin
                if (k == 13) begin
                    if (f == 0) dcache_addr = 16'hB104;
                    else if (f_d[f]) dcache_miss = 1'b0;
                    else icache_miss = 1'b0;
                end
                @(negedge clk);
                e = exp_vec(k, f_d[f], f_base[f], 4);
                checks++;
                if (obs_vec() !== e) begin
                    failures++; $display("FAIL tie f=%0d k=%0d got=%h exp=%h", f, k, obs_vec(), e);
                end
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++; $display("FAIL tie_idle got=%h exp=%h", obs_vec(), 25'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_fill_miss();
        logic [24:0] e;
        lat = 4; icache_addr = 16'h2000; icache_miss = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k <= 13; k++) begin
                if (f == 0 && k == 3) begin
                    dcache_addr = 16'h3458; dcache_miss = 1'b1;
                end
                if (k == 13) begin
                    if (f == 0) icache_miss = 1'b0;
                    else dcache_miss = 1'b0;
                end
                @(negedge clk);
                e = (f == 0) ? exp_vec(k, 1'b0, 16'h2000, 4) : exp_vec(k, 1'b1, 16'h3450, 4);
                checks++;
                if (obs_vec() !== e) begin
                    failures++; $display("FAIL mid_fill f=%0d k=%0d got=%h exp=%h", f, k, obs_vec(), e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [24:0] e;
        lat = 4; icache_addr = 16'h4448; icache_miss = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            e = exp_vec(k, 1'b0, 16'h4440, 4);
            checks++;
            if (obs_vec() !== e) begin
                failures++; $display("FAIL rst_fill k=%0d got=%h exp=%h", k, obs_vec(), e);
            end
            if (k < 8) begin
                @(posedge clk); #1;
            end
        end
        // Word 3 is on the bus; pull reset in the middle of the cycle.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++; $display("FAIL rst_async got=%h exp=%h", obs_vec(), 25'd0);
        end
        icache_miss = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst = 1'b1;
            @(negedge clk);
            checks++;
            if (obs_vec() !== 25'd0) begin
                failures++; $display("FAIL rst_stale c=%0d got=%h exp=%h", c, obs_vec(), 25'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_latency1();
        logic [24:0] e;
        lat = 1; dcache_addr = 16'h0F0E; dcache_miss = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k == 10) dcache_miss = 1'b0;
            @(negedge clk);
            e = exp_vec(k, 1'b1, 16'h0F00, 1);
            checks++;
            if (obs_vec() !== e) begin
                failures++; $display("FAIL lat1 k=%0d got=%h exp=%h", k, obs_vec(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_i_miss();
        test_tie();
        test_mid_fill_miss();
        test_reset_mid_fill();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
